// File: rtl/serial_cmd_sched_pkg.sv
// Shared types and constants for the serial command scheduler: FSM encodings,
// command bytes, response codes and frame geometry.
package serial_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SAMPLE,
        ST_FRAME
    } sched_state_t;

    typedef enum logic [1:0] {
        HS_SEND,
        HS_ACK,
        HS_DRAIN
    } hs_state_t;

    localparam logic [7:0] CMD_X       = 8'h78;
    localparam logic [7:0] CMD_Y       = 8'h79;
    localparam logic [7:0] CMD_Z       = 8'h7A;
    localparam logic [7:0] RSP_UNKNOWN = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h45;

    localparam int FRAME_LEN = 4;

    function automatic logic is_axis_cmd(input logic [7:0] cmd);
        return (cmd == CMD_X) || (cmd == CMD_Y) || (cmd == CMD_Z);
    endfunction

    function automatic logic [1:0] axis_of(input logic [7:0] cmd);
        logic [1:0] axis;
        case (cmd)
            CMD_Y:   axis = 2'd1;
            CMD_Z:   axis = 2'd2;
            default: axis = 2'd0;
        endcase
        return axis;
    endfunction

endpackage

// File: rtl/serial_cmd_sched_if.sv
// Bundles the UART rx/tx, accelerometer sample and status signals seen by the
// scheduler; master is the scheduler side, slave is its surroundings.
interface serial_cmd_sched_if #(
    parameter int DROP_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              tx_busy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic [15:0]       sample_data;
    logic              sample_valid;
    logic [1:0]        dimension;
    logic              sched_busy;
    logic [DROP_W-1:0] drop_count;
    logic              tx_err;

    modport master (
        input  rx_data, rx_ready, tx_busy, sample_data, sample_valid,
        output tx_start, tx_data, dimension, sched_busy, drop_count, tx_err
    );

    modport slave (
        output rx_data, rx_ready, tx_busy, sample_data, sample_valid,
        input  tx_start, tx_data, dimension, sched_busy, drop_count, tx_err
    );
endinterface

// File: rtl/serial_cmd_sched_uart_tx_handshake.sv
// Moves one byte through the transmitter start/busy handshake: launch when idle,
// wait (bounded) for busy to rise, wait for busy to fall, then pulse done.
module uart_tx_handshake
    import serial_cmd_pkg::*;
#(
    parameter int ACK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       done,
    output logic       ack_timeout
);

    localparam int AW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES + 1) : 1;

    hs_state_t      state_reg, state_next;
    logic [AW-1:0]  ack_cnt_reg;
    logic           tx_start_reg;
    logic [7:0]     tx_data_reg;
    logic           launch;

    always_comb begin
        state_next  = state_reg;
        launch      = 1'b0;
        done        = 1'b0;
        ack_timeout = 1'b0;
        case (state_reg)
            HS_SEND: begin
                if (req && !tx_busy) begin
                    launch     = 1'b1;
                    state_next = HS_ACK;
                end
            end
            HS_ACK: begin
                if (tx_busy) begin
                    state_next = HS_DRAIN;
                end else if (ack_cnt_reg == AW'(ACK_CYCLES - 1)) begin
                    ack_timeout = 1'b1;
                    state_next  = HS_DRAIN;
                end
            end
            HS_DRAIN: begin
                if (!tx_busy) begin
                    done       = 1'b1;
                    state_next = HS_SEND;
                end
            end
            default: state_next = HS_SEND;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= HS_SEND;
        end else begin
            state_reg <= state_next;
        end
    end

    // tx_data only moves on a launch, so it stays put for the whole busy window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cnt_reg  <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            tx_start_reg <= launch;
            if (launch) begin
                tx_data_reg <= byte_in;
                ack_cnt_reg <= '0;
            end else if (state_reg == HS_ACK) begin
                ack_cnt_reg <= ack_cnt_reg + AW'(1);
            end
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;

endmodule

// File: rtl/serial_cmd_sched.sv
// Command scheduler: decodes axis bytes from the UART, waits for a fresh sample
// (or times out) and returns a framed response through the transmitter.
module serial_cmd_sched
    import serial_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 500000,
    parameter int ACK_CYCLES     = 16,
    parameter int DROP_W         = 8
) (
    input  logic                CLK_50,
    input  logic                dly_rst,
    serial_cmd_sched_if.master  bus
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    sched_state_t       state_reg, state_next;
    logic               slot_full_reg;
    logic [7:0]         slot_data_reg;
    logic [1:0]         dimension_reg;
    logic [7:0]         hdr_reg, lo_reg, hi_reg;
    logic [1:0]         idx_reg, last_idx_reg;
    logic [TW-1:0]      timer_reg;
    logic [DROP_W-1:0]  drop_count_reg;
    logic               tx_err_reg;

    logic               pop, capture, drop;
    logic               timer_expired, last_byte;
    logic [7:0]         frame_byte;
    logic               hs_req, hs_done, hs_ack_timeout;
    logic               hs_tx_start;
    logic [7:0]         hs_tx_data;

    // The slot is popped before the capture check, so a byte arriving on a pop
    // cycle lands in the slot instead of being dropped.
    assign pop           = (state_reg == ST_IDLE) && slot_full_reg;
    assign capture       = bus.rx_ready && (!slot_full_reg || pop);
    assign drop          = bus.rx_ready && slot_full_reg && !pop;
    assign timer_expired = (timer_reg == TW'(TIMEOUT_CYCLES - 1));
    assign last_byte     = (idx_reg == last_idx_reg);
    assign hs_req        = (state_reg == ST_FRAME);

    always_comb begin
        frame_byte = hdr_reg;
        case (idx_reg)
            2'd1:    frame_byte = lo_reg;
            2'd2:    frame_byte = hi_reg;
            2'd3:    frame_byte = hdr_reg ^ lo_reg ^ hi_reg;
            default: frame_byte = hdr_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (slot_full_reg) begin
                    state_next = is_axis_cmd(slot_data_reg) ? ST_WAIT_SAMPLE : ST_FRAME;
                end
            end
            ST_WAIT_SAMPLE: begin
                if (bus.sample_valid || timer_expired) begin
                    state_next = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (hs_done && last_byte) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or posedge dly_rst) begin
        if (dly_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK_50 or posedge dly_rst) begin
        if (dly_rst) begin
            slot_full_reg  <= 1'b0;
            slot_data_reg  <= 8'h00;
            dimension_reg  <= 2'd0;
            hdr_reg        <= 8'h00;
            lo_reg         <= 8'h00;
            hi_reg         <= 8'h00;
            idx_reg        <= 2'd0;
            last_idx_reg   <= 2'd0;
            timer_reg      <= '0;
            drop_count_reg <= '0;
            tx_err_reg     <= 1'b0;
        end else begin
            if (capture) begin
                slot_full_reg <= 1'b1;
                slot_data_reg <= bus.rx_data;
            end else if (pop) begin
                slot_full_reg <= 1'b0;
            end

            if (drop && !(&drop_count_reg)) begin
                drop_count_reg <= drop_count_reg + DROP_W'(1);
            end

            if (hs_ack_timeout) begin
                tx_err_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        idx_reg   <= 2'd0;
                        timer_reg <= '0;
                        if (is_axis_cmd(slot_data_reg)) begin
                            dimension_reg <= axis_of(slot_data_reg);
                            hdr_reg       <= slot_data_reg;
                            last_idx_reg  <= 2'(FRAME_LEN - 1);
                        end else begin
                            hdr_reg      <= RSP_UNKNOWN;
                            last_idx_reg <= 2'd0;
                        end
                    end
                end
                ST_WAIT_SAMPLE: begin
                    // A sample on the final timer cycle still wins over the timeout.
                    if (bus.sample_valid) begin
                        lo_reg <= bus.sample_data[7:0];
                        hi_reg <= bus.sample_data[15:8];
                    end else if (timer_expired) begin
                        hdr_reg <= RSP_TIMEOUT;
                        lo_reg  <= 8'h00;
                        hi_reg  <= 8'h00;
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end
                ST_FRAME: begin
                    if (hs_done && !last_byte) begin
                        idx_reg <= idx_reg + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    uart_tx_handshake #(
        .ACK_CYCLES (ACK_CYCLES)
    ) u_tx_hs (
        .clk         (CLK_50),
        .rst         (dly_rst),
        .req         (hs_req),
        .byte_in     (frame_byte),
        .tx_busy     (bus.tx_busy),
        .tx_start    (hs_tx_start),
        .tx_data     (hs_tx_data),
        .done        (hs_done),
        .ack_timeout (hs_ack_timeout)
    );

    assign bus.tx_start   = hs_tx_start;
    assign bus.tx_data    = hs_tx_data;
    assign bus.dimension  = dimension_reg;
    assign bus.sched_busy = (state_reg != ST_IDLE);
    assign bus.drop_count = drop_count_reg;
    assign bus.tx_err     = tx_err_reg;

endmodule

// File: tb/tb_serial_cmd_sched.sv
// Bench for serial_cmd_sched: directed scenarios plus randomized commands, checked
// against a frame-level model and a behavioural transmitter.
module tb_serial_cmd_sched;

    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_cmd_sched_if #(.DROP_W(8)) bus ();

    serial_cmd_sched #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .ACK_CYCLES     (16),
        .DROP_W         (8)
    ) dut (
        .CLK_50  (clk),
        .dly_rst (rst),
        .bus     (bus)
    );

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [7:0] tx_log[$];
    logic [7:0] exp_q[$];
    logic [1:0] exp_dim = 2'd0;

    // transmitter model state
    int         busy_len  = 3;
    bit         tx_mute   = 1'b0;
    int         busy_left = 0;
    logic       tx_busy_m = 1'b0;
    int         start_cnt = 0;
    int         busy_viol = 0;
    int         hold_viol = 0;
    logic [7:0] last_tx   = 8'h00;

    assign bus.tx_busy = tx_busy_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter: each start logs the byte and holds busy for busy_len cycles.
    always @(negedge clk) begin
        if (rst) last_tx = 8'h00;
        if (bus.tx_start === 1'b1) begin
            if (tx_busy_m) busy_viol++;
            tx_log.push_back(bus.tx_data);
            last_tx   = bus.tx_data;
            start_cnt++;
            busy_left = tx_mute ? 0 : busy_len;
        end else begin
            if (tx_busy_m && bus.tx_data !== last_tx) hold_viol++;
            if (busy_left > 0) busy_left--;
        end
        tx_busy_m = (busy_left > 0);
    end

    function automatic void model_cmd(input logic [7:0] cmd, input bit has_sample, input logic [15:0] s);
        logic [7:0] h, lo, hi;
        if (cmd == 8'h78 || cmd == 8'h79 || cmd == 8'h7A) begin
            h  = has_sample ? cmd : 8'h45;
            lo = has_sample ? s[7:0] : 8'h00;
            hi = has_sample ? s[15:8] : 8'h00;
            exp_q.push_back(h);
            exp_q.push_back(lo);
            exp_q.push_back(hi);
            exp_q.push_back(h ^ lo ^ hi);
            exp_dim = 2'(cmd - 8'h78);
        end else begin
            exp_q.push_back(8'h3F);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic pulse_sample(input logic [15:0] s);
        bus.sample_data  = s;
        bus.sample_valid = 1'b1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(tx_log.size() >= exp_q.size() && bus.sched_busy === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_done"}, 32'(n < budget), 32'd1);
        check_val({tag, "_len"}, tx_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), tx_log[i], exp_q[i]);
        $display("frame %-12s: %0d bytes sent, %0d expected, dimension=%0d",
                 tag, tx_log.size(), exp_q.size(), bus.dimension);
        tx_log.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int         n;
    int         n0;
    int         pick;
    int         dly;
    bit         has_s;
    bit         axis;
    logic [7:0] cmd;
    logic [15:0] smp;

    initial begin
        bus.rx_data      = 8'h00;
        bus.rx_ready     = 1'b0;
        bus.sample_data  = 16'h0000;
        bus.sample_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_tx_start",   bus.tx_start,   0);
        check_val("rst_tx_data",    bus.tx_data,    0);
        check_val("rst_dimension",  bus.dimension,  0);
        check_val("rst_sched_busy", bus.sched_busy, 0);
        check_val("rst_drop_count", bus.drop_count, 0);
        check_val("rst_tx_err",     bus.tx_err,     0);
        rst = 1'b0;
        tick(2);

        // 'y' with sample 0x1234, including the two-cycle start latency
        busy_len = 3;
        send_byte(8'h79);
        model_cmd(8'h79, 1'b1, 16'h1234);
        tick(3);
        pulse_sample(16'h1234);
        check_val("lat_pre", bus.tx_start, 0);
        @(negedge clk);
        check_val("lat_start", bus.tx_start, 1);
        wait_frame("y_cmd", 200);
        check_val("y_dim", bus.dimension, exp_dim);

        // unknown byte: single 0x3F, dimension unchanged
        send_byte(8'h61);
        model_cmd(8'h61, 1'b0, 16'h0);
        wait_frame("unknown", 100);
        check_val("unk_dim", bus.dimension, exp_dim);
        check_val("unk_tx_idle", tx_busy_m, 0);

        // 'z' with no sample: timeout frame
        send_byte(8'h7A);
        model_cmd(8'h7A, 1'b0, 16'h0);
        tick(50);
        check_val("z_still_waiting", tx_log.size(), 0);
        check_val("z_busy", bus.sched_busy, 1);
        wait_frame("z_timeout", 400);
        check_val("z_dim", bus.dimension, exp_dim);

        // x,y,z back to back: z dropped, stale samples ignored
        check_val("drop_init", bus.drop_count, 0);
        pulse_sample(16'hDEAD);
        send_byte(8'h78);
        send_byte(8'h79);
        send_byte(8'h7A);
        model_cmd(8'h78, 1'b1, 16'hBEEF);
        model_cmd(8'h79, 1'b1, 16'hCAFE);
        tick(3);
        pulse_sample(16'hBEEF);
        n = 0;
        while (n < 300 && bus.dimension !== 2'd1) begin
            @(negedge clk);
            n++;
        end
        check_val("y_popped", 32'(n < 300), 1);
        tick(2);
        pulse_sample(16'hCAFE);
        wait_frame("drop_seq", 400);
        check_val("drop_count", bus.drop_count, 1);
        check_val("drop_dim", bus.dimension, exp_dim);

        // randomized commands
        for (int it = 0; it < 20; it++) begin
            pick     = int'($urandom_range(0, 3));
            cmd      = (pick == 3) ? 8'($urandom) : 8'(8'h78 + pick);
            axis     = (cmd == 8'h78 || cmd == 8'h79 || cmd == 8'h7A);
            has_s    = ($urandom_range(0, 3) != 0);
            smp      = 16'($urandom);
            dly      = int'($urandom_range(2, 60));
            busy_len = int'($urandom_range(1, 6));
            send_byte(cmd);
            model_cmd(cmd, has_s, smp);
            if (axis && has_s) begin
                tick(dly);
                pulse_sample(smp);
            end
            wait_frame($sformatf("rnd%0d_%02h", it, cmd), 500);
            check_val($sformatf("rnd%0d_dim", it), bus.dimension, exp_dim);
        end

        // transmitter never acknowledges: tx_err after 16 cycles, frame completes
        check_val("err_clear", bus.tx_err, 0);
        tx_mute = 1'b1;
        send_byte(8'h78);
        model_cmd(8'h78, 1'b1, 16'h0F0F);
        tick(3);
        pulse_sample(16'h0F0F);
        @(negedge clk);
        check_val("err_first_start", bus.tx_start, 1);
        tick(15);
        check_val("err_not_yet", bus.tx_err, 0);
        tick(1);
        check_val("err_set", bus.tx_err, 1);
        wait_frame("ack_err", 300);
        check_val("err_sticky", bus.tx_err, 1);
        tx_mute = 1'b0;

        // reset mid-frame
        busy_len = 4;
        send_byte(8'h79);
        tick(3);
        pulse_sample(16'h5555);
        n = 0;
        while (n < 300 && tx_log.size() < 2) begin
            @(negedge clk);
            n++;
        end
        check_val("rst_prelude", 32'(n < 300), 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_tx_start",   bus.tx_start,   0);
        check_val("arst_tx_data",    bus.tx_data,    0);
        check_val("arst_dimension",  bus.dimension,  0);
        check_val("arst_sched_busy", bus.sched_busy, 0);
        check_val("arst_drop_count", bus.drop_count, 0);
        check_val("arst_tx_err",     bus.tx_err,     0);
        n0 = start_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tick(40);
        check_val("no_start_after_rst", start_cnt, n0);
        tx_log.delete();
        exp_q.delete();
        exp_dim = 2'd0;
        send_byte(8'h78);
        model_cmd(8'h78, 1'b1, 16'hA5C3);
        tick(3);
        pulse_sample(16'hA5C3);
        wait_frame("post_rst", 200);
        check_val("post_rst_dim", bus.dimension, exp_dim);

        check_val("start_while_busy", busy_viol, 0);
        check_val("tx_data_hold", hold_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
